// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory with valid/ready requests, configurable read latency and clear-on-reset
module data_mem_ctrl #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {INIT, IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_q, clr_d;
    logic [1:0]        lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       pend_q, pend_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_widx;
    logic [31:0]       mem_wdata;

    logic [ADDR_W-3:0] widx;
    logic [AW-1:0]     idx;
    logic [31:0]       rd_word, ld_data, mask, wd_rep;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              req_err, accept;

    assign widx    = req_addr[ADDR_W-1:2];
    assign idx     = widx[AW-1:0];
    assign rd_word = mem[idx];
    assign byte_v  = rd_word[{req_addr[1:0], 3'b000} +: 8];
    assign half_v  = rd_word[{req_addr[1], 4'b0000} +: 16];
    assign req_err = (|(widx >> AW)) || req_size == 2'b11 || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign accept  = req_valid && ready_q;
    assign ld_data = req_size == 2'b00 ? {{24{req_signed & byte_v[7]}}, byte_v} :
                     req_size == 2'b01 ? {{16{req_signed & half_v[15]}}, half_v} : rd_word;
    assign mask    = req_size == 2'b00 ? 32'hFF << {req_addr[1:0], 3'b000} :
                     req_size == 2'b01 ? 32'hFFFF << {req_addr[1], 4'b0000} : '1;
    assign wd_rep  = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                     req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        pend_d      = pend_q;
        mem_we      = 1'b0;
        mem_widx    = clr_q;
        mem_wdata   = '0;
        case (state_q)
            INIT: begin
                if (INIT_CLEAR == 0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    clr_d  = clr_q + 1'b1;
                    if (clr_q == AW'(DEPTH - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            IDLE, WAIT: begin
                if (state_q == WAIT && !rsp_valid_q) begin
                    lat_d = lat_q - 1'b1;
                    if (lat_q == 2'd1) begin
                        rsp_valid_d = 1'b1;
                        ready_d     = 1'b1;
                        rdata_d     = pend_q;
                        err_d       = 1'b0;
                    end
                end else if (accept) begin
                    state_d   = WAIT;
                    mem_we    = req_write && !req_err;
                    mem_widx  = idx;
                    mem_wdata = (rd_word & ~mask) | (wd_rep & mask);
                    // errors and stores always answer on the next cycle; loads may wait longer
                    if (req_err || req_write || RD_LAT == 1) begin
                        rsp_valid_d = 1'b1;
                        ready_d     = 1'b1;
                        rdata_d     = (req_err || req_write) ? '0 : ld_data;
                        err_d       = req_err;
                    end else begin
                        ready_d = 1'b0;
                        lat_d   = 2'(RD_LAT - 1);
                        pend_d  = ld_data;
                    end
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            clr_q       <= '0;
            lat_q       <= '0;
            busy_q      <= INIT_CLEAR != 0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[mem_widx] <= mem_wdata;
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign init_busy = busy_q;
endmodule
